move_input_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/move_input_ctrl.sv | 82 ++++++++
 tb/tb_move_input_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared direction encoding, FSM states and priority helper for the 2048 input path.
package game_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;
  localparam int NUM_BTN   = 4;

  typedef logic [3:0] dir_t;

  typedef enum logic [1:0] {IDLE, PEND, WAIT_REL} state_t;

  // Keep only the highest-priority set bit: up > down > left > right.
  function automatic dir_t prio_onehot(input dir_t p);
    dir_t r;
    r = '0;
    if (p[DIR_UP])         r[DIR_UP]    = 1'b1;
    else if (p[DIR_DOWN])  r[DIR_DOWN]  = 1'b1;
    else if (p[DIR_LEFT])  r[DIR_LEFT]  = 1'b1;
    else if (p[DIR_RIGHT]) r[DIR_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and
// a registered one-cycle pulse on each 0->1 change of the level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  assign s = sync[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], raw};
  end

  // Count consecutive cycles that disagree with the level; any bounce restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s != level) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered rising-edge detect on the debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four debounced direction buttons into single move requests on a
// valid/ready handshake; a new move needs all buttons released first.
module move_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ar,
  input  logic       ab,
  input  logic       iz,
  input  logic       de,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [3:0] move_dir,
  output logic [3:0] btn_level
);

  dir_t   raw;
  dir_t   press;
  state_t state, state_d;
  dir_t   dir_q, dir_d;

  // Bit order matches move_dir: [3]=up [2]=down [1]=left [0]=right.
  assign raw = BTN_ACTIVE_LOW ? ~{ar, ab, iz, de} : {ar, ab, iz, de};

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw),
    .level (btn_level),
    .rise  (press)
  );

  // State and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= '0;
    end else begin
      state <= state_d;
      dir_q <= dir_d;
    end
  end

  // Next state: latch one move, hold it until accepted, then wait for release.
  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    case (state)
      IDLE: begin
        if (|press) begin
          state_d = PEND;
          dir_d   = prio_onehot(press);
        end
      end
      PEND: begin
        if (move_ready) begin
          state_d = WAIT_REL;
          dir_d   = '0;
        end
      end
      WAIT_REL: begin
        if (btn_level == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dir_d   = '0;
      end
    endcase
  end

  assign move_valid = (state == PEND);
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with a short debounce window.
module tb_move_input_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, ar, ab, iz, de, move_ready;
  logic       move_valid;
  logic [3:0] move_dir, btn_level;

  int nvec = 0;
  int nerr = 0;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ar         (ar),
    .ab         (ab),
    .iz         (iz),
    .de         (de),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .btn_level  (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ar, ab, iz, de, rdy;
    logic       ev;
    logic [3:0] edir;
    logic [3:0] elvl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, a, b, i, d, rdy,
                     input logic ev, input logic [3:0] edir, elvl);
    vec_t v;
    v.rst = r; v.ar = a; v.ab = b; v.iz = i; v.de = d; v.rdy = rdy;
    v.ev = ev; v.edir = edir; v.elvl = elvl;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, then advance past the next rising edge.
  task automatic step(input logic r, a, b, i, d, rdy);
    rst = r; ar = a; ab = b; iz = i; de = d; move_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Run n cycles with fixed inputs; count cycles with a move offered.
  task automatic run(input int n, input logic a, b, i, d, rdy,
                     output int moves, output logic [3:0] last_dir);
    moves = 0;
    last_dir = '0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, a, b, i, d, rdy);
      if (move_valid) begin
        moves++;
        last_dir = move_dir;
      end
    end
  endtask

  initial begin
    int         mv;
    logic [3:0] ld;
    logic       stable;

    rst = 1'b1; ar = 1'b0; ab = 1'b0; iz = 1'b0; de = 1'b0; move_ready = 1'b0;

    // Reset with up held, then a clean press, hold, release and re-press.
    add(2, 1, 1,0,0,0, 1, 0, 4'h0, 4'h0);
    add(5, 0, 1,0,0,0, 1, 0, 4'h0, 4'h0);
    add(1, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);
    add(1, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);
    add(1, 0, 1,0,0,0, 1, 1, 4'h8, 4'h8);
    add(6, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);
    add(5, 0, 0,0,0,0, 1, 0, 4'h0, 4'h8);
    add(1, 0, 0,0,0,0, 1, 0, 4'h0, 4'h0);
    add(5, 0, 1,0,0,0, 1, 0, 4'h0, 4'h0);
    add(1, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);
    add(1, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);
    add(1, 0, 1,0,0,0, 1, 1, 4'h8, 4'h8);
    add(5, 0, 1,0,0,0, 1, 0, 4'h0, 4'h8);

    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].rst, tbl[v].ar, tbl[v].ab, tbl[v].iz, tbl[v].de, tbl[v].rdy);
      chk($sformatf("tbl%0d_valid", v), move_valid, tbl[v].ev);
      chk($sformatf("tbl%0d_dir", v),   move_dir,   tbl[v].edir);
      chk($sformatf("tbl%0d_level", v), btn_level,  tbl[v].elvl);
    end

    // Release up and settle back to idle.
    run(12, 0,0,0,0, 1, mv, ld);
    chk("release_no_move", mv, 0);
    chk("release_level", btn_level, 0);

    // Bouncing right button: level only after four stable synced highs.
    step(0, 0,0,0,1, 1);
    step(0, 0,0,0,0, 1);
    step(0, 0,0,0,1, 1);
    step(0, 0,0,0,0, 1);
    mv = 0;
    for (int j = 0; j < 16; j++) begin
      step(0, 0,0,0,1, 1);
      if (move_valid) mv++;
      if (j == 4) chk("bounce_level_early", btn_level, 4'h0);
      if (j == 5) chk("bounce_level_rise", btn_level, 4'h1);
      if (j == 7) begin
        chk("bounce_valid", move_valid, 1);
        chk("bounce_dir", move_dir, 4'h1);
      end
    end
    chk("bounce_moves", mv, 1);

    // Back-pressure on a left move; down pressed while pending is dropped.
    run(12, 0,0,0,0, 0, mv, ld);
    for (int j = 0; j < 8; j++) begin
      step(0, 0,0,1,0, 0);
      if (j == 6) chk("bp_valid_early", move_valid, 0);
    end
    chk("bp_valid", move_valid, 1);
    chk("bp_dir", move_dir, 4'h2);
    stable = 1'b1;
    for (int j = 0; j < 30; j++) begin
      step(0, 0, (j >= 5 && j < 15), 1, 0, 0);
      if (!move_valid || move_dir != 4'h2) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    step(0, 0,0,1,0, 1);
    chk("bp_accept_valid", move_valid, 0);
    chk("bp_accept_dir", move_dir, 4'h0);
    run(20, 0,0,0,0, 1, mv, ld);
    chk("bp_no_down", mv, 0);

    // Simultaneous up+right: only up issued; right-only hold keeps waiting.
    run(12, 1,0,0,1, 1, mv, ld);
    chk("simul_moves", mv, 1);
    chk("simul_dir", ld, 4'h8);
    run(20, 0,0,0,1, 1, mv, ld);
    chk("simul_hold_moves", mv, 0);
    chk("simul_hold_level", btn_level, 4'h1);
    run(12, 0,0,0,0, 1, mv, ld);
    run(12, 0,0,0,1, 1, mv, ld);
    chk("simul_repress_moves", mv, 1);
    chk("simul_repress_dir", ld, 4'h1);

    // Reset while a down move is pending; held button re-fires afterwards.
    run(12, 0,0,0,0, 0, mv, ld);
    for (int j = 0; j < 8; j++) step(0, 0,1,0,0, 0);
    chk("rst_pend_valid", move_valid, 1);
    step(1, 0,1,0,0, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_dir", move_dir, 4'h0);
    chk("rst_level", btn_level, 4'h0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0,1,0,0, 0);
      if (j == 6) chk("rst_refire_early", move_valid, 0);
    end
    chk("rst_refire_valid", move_valid, 1);
    chk("rst_refire_dir", move_dir, 4'h4);
    step(0, 0,1,0,0, 1);
    chk("rst_refire_accept", move_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
